// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes,
// default timing parameters and the Moore output decode.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIA_RODADA = 4'h2,
    MOSTRA        = 4'h3,
    PROX_LED      = 4'h4,
    FIM_MOSTRA    = 4'h5,
    ESPERA        = 4'h6,
    REGISTRA      = 4'h7,
    COMPARA       = 4'h8,
    PROX_JOGADA   = 4'h9,
    PROX_RODADA   = 4'hA,
    FIM_ACERTOU   = 4'hB,
    FIM_ERROU     = 4'hC,
    FIM_TIMEOUT   = 4'hD,
    INVALIDO_E    = 4'hE,
    INVALIDO_F    = 4'hF
  } estado_t;

  localparam int LED_CYCLES_DEF     = 50;
  localparam int TIMEOUT_CYCLES_DEF = 5000;

  typedef struct packed {
    logic zera_E;
    logic conta_E;
    logic zera_R;
    logic conta_R;
    logic registra_R;
    logic mostra_leds;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } saidas_t;

  // Each state owns a fixed set of strobes; everything else stays low.
  function automatic saidas_t decodifica_saidas(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA: begin
        s.zera_E = 1'b1;
        s.zera_R = 1'b1;
      end
      INICIA_RODADA: s.zera_E      = 1'b1;
      MOSTRA:        s.mostra_leds = 1'b1;
      PROX_LED:      s.conta_E     = 1'b1;
      FIM_MOSTRA:    s.zera_E      = 1'b1;
      REGISTRA:      s.registra_R  = 1'b1;
      PROX_JOGADA:   s.conta_E     = 1'b1;
      PROX_RODADA:   s.conta_R     = 1'b1;
      FIM_ACERTOU: begin
        s.pronto = 1'b1;
        s.ganhou = 1'b1;
      end
      FIM_ERROU: begin
        s.pronto = 1'b1;
        s.perdeu = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.pronto     = 1'b1;
        s.perdeu     = 1'b1;
        s.db_timeout = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/contador_temporizador.sv
// Saturating cycle timer: counts while enabled, flags when it reaches
// limit-1 and then holds there until cleared.
module contador_temporizador #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         fim
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign fim = (count_q == (limit - W'(1)));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !fim) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Round-control FSM of the memory game: plays the stored sequence on the
// LEDs, waits for and checks each button play, and reports win/loss/timeout.
module unidade_controle_rodadas
  import jogo_pkg::*;
#(
  parameter int LED_CYCLES     = LED_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMER_W        = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       jogada_correta,
  input  logic       endereco_igual_rodada,
  input  logic       fim_rodada,
  output logic       zera_E,
  output logic       conta_E,
  output logic       zera_R,
  output logic       conta_R,
  output logic       registra_R,
  output logic       mostra_leds,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t              estado_q;
  estado_t              estado_d;
  saidas_t              saidas_q;
  logic                 timer_en;
  logic                 timer_fim;
  logic [TIMER_W-1:0]   timer_limit;

  // One shared timer: LED window while showing, play deadline while waiting.
  assign timer_en    = (estado_q == MOSTRA) || (estado_q == ESPERA);
  assign timer_limit = (estado_q == MOSTRA) ? TIMER_W'(LED_CYCLES)
                                            : TIMER_W'(TIMEOUT_CYCLES);

  contador_temporizador #(
    .W(TIMER_W)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (!timer_en),
    .enable(timer_en),
    .limit (timer_limit),
    .fim   (timer_fim)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:       if (jogar) estado_d = PREPARA;
      PREPARA:       estado_d = INICIA_RODADA;
      INICIA_RODADA: estado_d = MOSTRA;
      MOSTRA: begin
        if (timer_fim) begin
          estado_d = endereco_igual_rodada ? FIM_MOSTRA : PROX_LED;
        end
      end
      PROX_LED:      estado_d = MOSTRA;
      FIM_MOSTRA:    estado_d = ESPERA;
      // A play arriving on the deadline cycle still counts.
      ESPERA: begin
        if (tem_jogada) begin
          estado_d = REGISTRA;
        end else if (timer_fim) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      REGISTRA:      estado_d = COMPARA;
      COMPARA: begin
        if (!jogada_correta) begin
          estado_d = FIM_ERROU;
        end else if (!endereco_igual_rodada) begin
          estado_d = PROX_JOGADA;
        end else if (fim_rodada) begin
          estado_d = FIM_ACERTOU;
        end else begin
          estado_d = PROX_RODADA;
        end
      end
      PROX_JOGADA:   estado_d = ESPERA;
      PROX_RODADA:   estado_d = INICIA_RODADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:   if (jogar) estado_d = PREPARA;
      default:       estado_d = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with estado_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= INICIAL;
      saidas_q <= '0;
    end else begin
      estado_q <= estado_d;
      saidas_q <= decodifica_saidas(estado_d);
    end
  end

  assign zera_E      = saidas_q.zera_E;
  assign conta_E     = saidas_q.conta_E;
  assign zera_R      = saidas_q.zera_R;
  assign conta_R     = saidas_q.conta_R;
  assign registra_R  = saidas_q.registra_R;
  assign mostra_leds = saidas_q.mostra_leds;
  assign pronto      = saidas_q.pronto;
  assign ganhou      = saidas_q.ganhou;
  assign perdeu      = saidas_q.perdeu;
  assign db_timeout  = saidas_q.db_timeout;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Self-checking bench for unidade_controle_rodadas: a cycle table, timeout
// corner sequences and randomized whole games against a game-level model.
module tb_unidade_controle_rodadas;

  localparam int LED = 4;
  localparam int TO  = 20;
  localparam int NR  = 4;

  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_PREP = 10'b1010000000;
  localparam logic [9:0] O_ZE   = 10'b1000000000;
  localparam logic [9:0] O_CE   = 10'b0100000000;
  localparam logic [9:0] O_CR   = 10'b0001000000;
  localparam logic [9:0] O_RR   = 10'b0000100000;
  localparam logic [9:0] O_ML   = 10'b0000010000;
  localparam logic [9:0] O_WIN  = 10'b0000001100;
  localparam logic [9:0] O_ERR  = 10'b0000001010;
  localparam logic [9:0] O_TO   = 10'b0000001011;

  typedef struct {
    logic       rst;
    logic       jog;
    logic       tem;
    logic       cor;
    logic       eq;
    logic       fim;
    logic [3:0] st;
    logic [9:0] outs;
  } vec_t;

  logic clock = 1'b0;
  logic reset, jogar, tem_jogada;
  logic jogada_correta, endereco_igual_rodada, fim_rodada;
  logic zera_E, conta_E, zera_R, conta_R, registra_R, mostra_leds;
  logic pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  // Table mode drives status flags directly; model mode derives them
  // from a small datapath that follows the DUT strobes.
  logic useModel;
  logic tCor, tEq, tFim;
  int   addr, rodada;
  logic errEn, toEn;
  int   errRound, errPlay, toRound, toPlay;

  int nCompared  = 0;
  int nMismatched = 0;

  vec_t tabela[$];

  always #5 clock = ~clock;

  unidade_controle_rodadas #(
    .LED_CYCLES    (LED),
    .TIMEOUT_CYCLES(TO),
    .TIMER_W       (16)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .jogar                (jogar),
    .tem_jogada           (tem_jogada),
    .jogada_correta       (jogada_correta),
    .endereco_igual_rodada(endereco_igual_rodada),
    .fim_rodada           (fim_rodada),
    .zera_E               (zera_E),
    .conta_E              (conta_E),
    .zera_R               (zera_R),
    .conta_R              (conta_R),
    .registra_R           (registra_R),
    .mostra_leds          (mostra_leds),
    .pronto               (pronto),
    .ganhou               (ganhou),
    .perdeu               (perdeu),
    .db_timeout           (db_timeout),
    .db_estado            (db_estado)
  );

  // Datapath model: address and round counters driven by the control strobes.
  always @(posedge clock) begin
    if (zera_E) addr <= 0;
    else if (conta_E) addr <= addr + 1;
    if (zera_R) rodada <= 0;
    else if (conta_R) rodada <= rodada + 1;
  end

  assign endereco_igual_rodada = useModel ? (addr == rodada) : tEq;
  assign fim_rodada            = useModel ? (rodada == NR - 1) : tFim;
  assign jogada_correta        = useModel ? !(errEn && rodada == errRound && addr == errPlay) : tCor;

  function automatic logic [9:0] packOut();
    return {zera_E, conta_E, zera_R, conta_R, registra_R, mostra_leds,
            pronto, ganhou, perdeu, db_timeout};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one row's inputs at the falling edge and checks after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    reset      = v.rst;
    jogar      = v.jog;
    tem_jogada = v.tem;
    tCor       = v.cor;
    tEq        = v.eq;
    tFim       = v.fim;
    @(negedge clock);
    checkOutput($sformatf("row%0d estado", idx), int'(db_estado), int'(v.st));
    checkOutput($sformatf("row%0d saidas", idx), int'(packOut()), int'(v.outs));
  endtask

  task automatic addRow(input logic rst, input logic jog, input logic tem, input logic cor,
                        input logic eq, input logic fim, input logic [3:0] st, input logic [9:0] o);
    vec_t v;
    v = '{rst, jog, tem, cor, eq, fim, st, o};
    tabela.push_back(v);
  endtask

  task automatic goToEspera(output bit ok);
    ok = 0;
    useModel = 0;
    tem_jogada = 0; tCor = 1; tEq = 1; tFim = 0;
    reset = 1; jogar = 0;
    @(negedge clock);
    reset = 0; jogar = 1;
    @(negedge clock);
    jogar = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (db_estado == 4'h6) ok = 1;
      else @(negedge clock);
    end
    if (!ok) checkOutput("reach espera", int'(db_estado), 6);
  endtask

  task automatic runGame(input int kind, input int g);
    int  cyc, espCycle, delay, windows, mlCycles, contaR, regs, s, expState, expRegs, stableErr;
    bit  done, prevMl, skip;
    errEn = (kind == 1);
    toEn  = (kind == 2);
    errRound = $urandom_range(0, NR - 1);
    errPlay  = $urandom_range(0, errRound);
    toRound  = $urandom_range(0, NR - 1);
    toPlay   = $urandom_range(0, toRound);
    useModel = 1;
    tem_jogada = 0;
    reset = 1; jogar = 0;
    @(negedge clock);
    reset = 0; jogar = 1;
    windows = 0; mlCycles = 0; contaR = 0; regs = 0;
    espCycle = 0; delay = $urandom_range(0, TO - 1);
    done = 0; prevMl = 0;
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clock);
      jogar = 0;
      if (mostra_leds && !prevMl) windows++;
      prevMl = mostra_leds;
      mlCycles += int'(mostra_leds);
      contaR   += int'(conta_R);
      regs     += int'(registra_R);
      if (pronto) done = 1;
      if (db_estado == 4'h6) begin
        skip = toEn && rodada == toRound && addr == toPlay;
        tem_jogada = !skip && (espCycle == delay);
        espCycle++;
      end else begin
        tem_jogada = 0;
        espCycle = 0;
        delay = $urandom_range(0, TO - 1);
      end
    end
    tem_jogada = 0;
    if (!done) begin
      checkOutput($sformatf("game%0d finished", g), 0, 1);
      return;
    end
    // Game-level expectations: round s is the last one played.
    s = (kind == 0) ? NR - 1 : (kind == 1 ? errRound : toRound);
    expState = (kind == 0) ? 11 : (kind == 1 ? 12 : 13);
    expRegs  = s * (s + 1) / 2 + ((kind == 0) ? s + 1 : (kind == 1 ? errPlay + 1 : toPlay));
    checkOutput($sformatf("game%0d estado", g), int'(db_estado), expState);
    checkOutput($sformatf("game%0d ganhou", g), int'(ganhou), int'(kind == 0));
    checkOutput($sformatf("game%0d perdeu", g), int'(perdeu), int'(kind != 0));
    checkOutput($sformatf("game%0d timeout", g), int'(db_timeout), int'(kind == 2));
    checkOutput($sformatf("game%0d led windows", g), windows, (s + 1) * (s + 2) / 2);
    checkOutput($sformatf("game%0d led cycles", g), mlCycles, LED * (s + 1) * (s + 2) / 2);
    checkOutput($sformatf("game%0d conta_R pulses", g), contaR, (kind == 0) ? NR - 1 : s);
    checkOutput($sformatf("game%0d plays", g), regs, expRegs);
    stableErr = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (db_estado != 4'(expState) || pronto !== 1'b1) stableErr++;
    end
    checkOutput($sformatf("game%0d hold", g), stableErr, 0);
  endtask

  initial begin
    bit ok;
    reset = 1; jogar = 0; tem_jogada = 0;
    tCor = 0; tEq = 0; tFim = 0;
    useModel = 0; errEn = 0; toEn = 0;
    errRound = 0; errPlay = 0; toRound = 0; toPlay = 0;
    addr = 0; rodada = 0;
    @(negedge clock);

    //     rst jog tem cor eq fim  st     outs
    addRow(1, 0, 0, 0, 0, 0, 4'h0, O_NONE);
    addRow(0, 1, 0, 0, 0, 0, 4'h1, O_PREP);
    addRow(0, 0, 0, 0, 0, 0, 4'h2, O_ZE);
    for (int i = 0; i < 4; i++) addRow(0, 0, 0, 0, 0, 0, 4'h3, O_ML);
    addRow(0, 0, 0, 0, 0, 0, 4'h4, O_CE);
    for (int i = 0; i < 4; i++) addRow(0, 0, 0, 0, 0, 0, 4'h3, O_ML);
    addRow(0, 0, 0, 0, 1, 0, 4'h5, O_ZE);
    addRow(0, 1, 0, 0, 0, 0, 4'h6, O_NONE);
    addRow(0, 0, 1, 0, 0, 0, 4'h7, O_RR);
    addRow(0, 0, 0, 0, 0, 0, 4'h8, O_NONE);
    addRow(0, 0, 0, 1, 0, 1, 4'h9, O_CE);
    addRow(0, 0, 0, 0, 0, 0, 4'h6, O_NONE);
    addRow(0, 0, 1, 0, 0, 0, 4'h7, O_RR);
    addRow(0, 0, 0, 0, 0, 0, 4'h8, O_NONE);
    addRow(0, 0, 0, 1, 1, 0, 4'hA, O_CR);
    addRow(0, 0, 0, 0, 0, 0, 4'h2, O_ZE);
    for (int i = 0; i < 4; i++) addRow(0, 0, 0, 0, 0, 0, 4'h3, O_ML);
    addRow(0, 0, 0, 0, 1, 0, 4'h5, O_ZE);
    addRow(0, 0, 0, 0, 0, 0, 4'h6, O_NONE);
    addRow(0, 0, 1, 0, 0, 0, 4'h7, O_RR);
    addRow(0, 0, 0, 0, 0, 0, 4'h8, O_NONE);
    addRow(0, 0, 0, 1, 1, 1, 4'hB, O_WIN);
    addRow(0, 0, 0, 0, 0, 0, 4'hB, O_WIN);
    addRow(0, 1, 0, 0, 0, 0, 4'h1, O_PREP);
    addRow(0, 0, 0, 0, 0, 0, 4'h2, O_ZE);
    addRow(0, 0, 0, 0, 0, 0, 4'h3, O_ML);
    addRow(1, 0, 0, 0, 0, 0, 4'h0, O_NONE);
    addRow(0, 0, 0, 0, 0, 0, 4'h0, O_NONE);
    addRow(0, 1, 0, 0, 0, 0, 4'h1, O_PREP);
    addRow(0, 0, 0, 0, 0, 0, 4'h2, O_ZE);
    for (int i = 0; i < 4; i++) addRow(0, 0, 0, 0, 0, 0, 4'h3, O_ML);
    addRow(0, 0, 0, 0, 1, 0, 4'h5, O_ZE);
    addRow(0, 0, 0, 0, 0, 0, 4'h6, O_NONE);
    addRow(0, 0, 1, 0, 0, 0, 4'h7, O_RR);
    addRow(0, 0, 0, 0, 0, 0, 4'h8, O_NONE);
    addRow(0, 0, 0, 0, 1, 1, 4'hC, O_ERR);
    addRow(0, 0, 0, 0, 0, 0, 4'hC, O_ERR);
    addRow(0, 1, 1, 0, 0, 0, 4'h1, O_PREP);

    foreach (tabela[i]) applyStimulus(tabela[i], i);

    // No play: still waiting after 19 cycles, timeout on the 20th.
    goToEspera(ok);
    if (ok) begin
      for (int i = 0; i < TO - 1; i++) @(negedge clock);
      checkOutput("espera before deadline", int'(db_estado), 6);
      @(negedge clock);
      checkOutput("timeout estado", int'(db_estado), 13);
      checkOutput("timeout saidas", int'(packOut()), int'(O_TO));
    end

    // Play on the deadline cycle beats the timeout.
    goToEspera(ok);
    if (ok) begin
      for (int i = 0; i < TO - 1; i++) @(negedge clock);
      tem_jogada = 1;
      @(negedge clock);
      tem_jogada = 0;
      checkOutput("late play estado", int'(db_estado), 7);
      checkOutput("late play no timeout", int'(db_timeout), 0);
    end

    for (int g = 0; g < 3; g++) runGame(g, g);
    for (int g = 3; g < 9; g++) runGame(int'($urandom_range(0, 2)), g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
